// File: rtl/mmc1_cpu_bus_sync.sv
// mmc1_cpu_bus_sync: oversamples the asynchronous NES cartridge CPU bus with CLK
// and turns every accepted write to $8000-$FFFF into one clean single-clock strobe
// for the MMC1 shift/register logic.
//
// Ports:
//   CLK, nRST              system clock, asynchronous active-low reset
//   CPU_M2 .. CPU_A14      raw cartridge bus (M2, /ROMSEL, R/W, D0, D7, A13, A14)
//   WR_STB                 one-CLK pulse per accepted ROM-space write
//   WR_REG                 {A14,A13} of that write, held until the next strobe
//   WR_D0                  D0 of that write (serial data bit)
//   WR_RESET               D7 of that write (shift-register reset request)
//   M2_IDLE                CPU clock absent (stalled or held in reset)
//
// Optional feature macro: MMC1_CONSEC_WRITE_FILTER_EN
//   When defined, a ROM write is ignored if the immediately preceding valid M2
//   cycle was also a ROM write (suppresses the 6502 read-modify-write double write).
module mmc1_cpu_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 4,
  parameter int unsigned M2_TIMEOUT  = 255
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       CPU_M2,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_D0,
  input  logic       CPU_D7,
  input  logic       CPU_A13,
  input  logic       CPU_A14,
  output logic       WR_STB,
  output logic [1:0] WR_REG,
  output logic       WR_D0,
  output logic       WR_RESET,
  output logic       M2_IDLE
);

  localparam int unsigned BUS_W = 7;
  localparam int unsigned CAP_W = 6;
  localparam int unsigned SYN_W = SYNC_STAGES * BUS_W;
  localparam int unsigned HC_W  = $clog2(MIN_HIGH + 1);
  localparam int unsigned TO_W  = $clog2(M2_TIMEOUT + 1);

  // Capture register bit positions
  localparam int unsigned C_NROMSEL = 0;
  localparam int unsigned C_NRW     = 1;
  localparam int unsigned C_D0      = 2;
  localparam int unsigned C_D7      = 3;
  localparam int unsigned C_A13     = 4;
  localparam int unsigned C_A14     = 5;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_EVAL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SYN_W-1:0]   sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic               vld_d1_q;
  logic               m2_prev_q;
  logic               low_seen_q, low_seen_d;
  logic [HC_W-1:0]    hcnt_q, hcnt_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               idle_q, idle_d;
  logic               stb_q, stb_d;
  logic [1:0]         reg_q, reg_d;
  logic               d0_q, d0_d;
  logic               rst_q, rst_d;

  logic [BUS_W-1:0]   bus_c;
  logic [BUS_W-1:0]   syn_c;
  logic               m2_s;
  logic               edge_c;
  logic               is_write_c;
  logic               filt_c;

  // All bus lines share one synchroniser so data stays aligned with M2
  assign bus_c      = {CPU_A14, CPU_A13, CPU_D7, CPU_D0, nCPU_RW, nCPU_ROMSEL, CPU_M2};
  assign syn_c      = sync_q[SYN_W-1 -: BUS_W];
  assign m2_s       = syn_c[0];
  // Edges only count once the chain holds real samples, not reset zeros
  assign edge_c     = vld_d1_q & (m2_s ^ m2_prev_q);
  assign is_write_c = ~cap_q[C_NROMSEL] & ~cap_q[C_NRW];

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  logic prev_write_q, prev_write_d;

  assign filt_c = prev_write_q;

  // Remembers whether the last evaluated M2 cycle was a ROM write
  always_comb begin
    prev_write_d = prev_write_q;
    if (idle_q) begin
      prev_write_d = 1'b0;
    end else if (state_q == ST_EVAL) begin
      prev_write_d = is_write_c;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prev_write_q <= 1'b0;
    end else begin
      prev_write_q <= prev_write_d;
    end
  end
`else
  assign filt_c = 1'b0;
`endif

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    cap_d      = cap_q;
    stb_d      = 1'b0;
    reg_d      = reg_q;
    d0_d       = d0_q;
    rst_d      = rst_q;
    low_seen_d = low_seen_q | (vld_q[SYNC_STAGES-1] & ~m2_s);

    unique case (state_q)
      ST_LOW: begin
        // A high phase already in progress at reset release is not evaluable
        if (m2_s && low_seen_q) begin
          state_d = ST_HIGH;
          hcnt_d  = '0;
        end
      end
      ST_HIGH: begin
        if (m2_s) begin
          cap_d = syn_c[BUS_W-1:1];
          if (hcnt_q != HC_W'(MIN_HIGH)) begin
            hcnt_d = hcnt_q + HC_W'(1);
          end
        end else if (hcnt_q == HC_W'(MIN_HIGH)) begin
          state_d = ST_EVAL;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_EVAL: begin
        if (is_write_c && !filt_c) begin
          stb_d = 1'b1;
          reg_d = {cap_q[C_A14], cap_q[C_A13]};
          d0_d  = cap_q[C_D0];
          rst_d = cap_q[C_D7];
        end
        hcnt_d  = '0;
        state_d = m2_s ? ST_HIGH : ST_LOW;
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase

    // M2 watchdog: cleared on every synced edge, saturates at the timeout
    if (edge_c) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_W'(M2_TIMEOUT)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    idle_d = edge_c ? 1'b0 : (idle_q | (to_cnt_d == TO_W'(M2_TIMEOUT)));
  end

  // State and data registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_LOW;
      sync_q     <= '0;
      vld_q      <= '0;
      vld_d1_q   <= 1'b0;
      m2_prev_q  <= 1'b0;
      low_seen_q <= 1'b0;
      hcnt_q     <= '0;
      cap_q      <= '1;
      to_cnt_q   <= '0;
      idle_q     <= 1'b1;
      stb_q      <= 1'b0;
      reg_q      <= 2'b00;
      d0_q       <= 1'b0;
      rst_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYN_W-BUS_W-1:0], bus_c};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      vld_d1_q   <= vld_q[SYNC_STAGES-1];
      m2_prev_q  <= m2_s;
      low_seen_q <= low_seen_d;
      hcnt_q     <= hcnt_d;
      cap_q      <= cap_d;
      to_cnt_q   <= to_cnt_d;
      idle_q     <= idle_d;
      stb_q      <= stb_d;
      reg_q      <= reg_d;
      d0_q       <= d0_d;
      rst_q      <= rst_d;
    end
  end

  assign WR_STB   = stb_q;
  assign WR_REG   = reg_q;
  assign WR_D0    = d0_q;
  assign WR_RESET = rst_q;
  assign M2_IDLE  = idle_q;

endmodule

// File: tb/tb_mmc1_cpu_bus_sync.sv
// Bench for mmc1_cpu_bus_sync: drives whole M2 cycles at CLK/16, predicts each
// strobe with a small bus model and checks it from a scoreboard queue.
module tb_mmc1_cpu_bus_sync;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned MINH  = 4;
  localparam int unsigned TOUT  = 255;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct {
    logic [1:0] r;
    logic       d0;
    logic       rst;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       nrst;
  logic       m2, nromsel, nrw, d0, d7, a13, a14;
  logic       wr_stb;
  logic [1:0] wr_reg;
  logic       wr_d0, wr_reset, m2_idle;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_errors;
  bit   prev_wr;

  mmc1_cpu_bus_sync #(
    .SYNC_STAGES (SYNC),
    .MIN_HIGH    (MINH),
    .M2_TIMEOUT  (TOUT)
  ) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .CPU_M2      (m2),
    .nCPU_ROMSEL (nromsel),
    .nCPU_RW     (nrw),
    .CPU_D0      (d0),
    .CPU_D7      (d7),
    .CPU_A13     (a13),
    .CPU_A14     (a14),
    .WR_STB      (wr_stb),
    .WR_REG      (wr_reg),
    .WR_D0       (wr_d0),
    .WR_RESET    (wr_reset),
    .M2_IDLE     (m2_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest prediction, at the predicted cycle
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (wr_stb) begin
        if (exp_q.size() == 0) begin
          check("unexpected_stb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stb_latency", cyc, e.cyc);
          check("wr_reg", int'(wr_reg), int'(e.r));
          check("wr_d0", int'(wr_d0), int'(e.d0));
          check("wr_reset", int'(wr_reset), int'(e.rst));
        end
      end
    end
  end

  // One M2 cycle: 8 CLK low, high_n CLK high; predicts the strobe at M2 fall
  task automatic bus_cycle(input logic n_rs, input logic n_rw, input logic ia14,
                           input logic ia13, input logic id7, input logic id0,
                           input int high_n);
    exp_t e;
    bit   wr;
    @(negedge clk);
    m2 = 1'b0; nromsel = n_rs; nrw = n_rw; a14 = ia14; a13 = ia13; d7 = id7; d0 = id0;
    repeat (7) @(negedge clk);
    m2 = 1'b1;
    repeat (high_n) @(negedge clk);
    m2 = 1'b0;
    wr = !n_rs && !n_rw;
    if (high_n > int'(MINH)) begin
      if (wr && !(FILT && prev_wr)) begin
        e.r   = {ia14, ia13};
        e.d0  = id0;
        e.rst = id7;
        e.cyc = cyc + int'(SYNC) + 2;
        exp_q.push_back(e);
      end
      prev_wr = wr;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_wr  = 1'b0;
    nrst = 1'b0;
    m2 = 1'b0; nromsel = 1'b1; nrw = 1'b1; d0 = 1'b0; d7 = 1'b0; a13 = 1'b0; a14 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stb", int'(wr_stb), 0);
    check("rst_reg", int'(wr_reg), 0);
    check("rst_d0", int'(wr_d0), 0);
    check("rst_reset", int'(wr_reset), 0);
    check("rst_idle", int'(m2_idle), 1);
    nrst = 1'b1;
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);   // idle read cycle to prime

    // Single writes and non-strobing accesses
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);   // write $8000 D=$01
    check("idle_clear", int'(m2_idle), 0);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8);   // write $E000 D=$80
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8);   // read $E000
    bus_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8);   // write $6000
    check("held_reg", int'(wr_reg), 3);
    check("held_reset", int'(wr_reset), 1);

    // INC $8000: write $FF then $00 back to back
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);

    // Write, read, write: two strobes regardless of filter
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8);   // $C000
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8);   // $A000

    // Short M2 pulses: ignored and do not touch the consecutive-write history
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);   // read
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, int'(MINH) - 1);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8);   // strobes
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, int'(MINH) - 1);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8);   // filter-dependent

    // M2 stall: watchdog asserts, history is dropped, first edge recovers
    repeat (250) @(negedge clk);
    check("idle_early", int'(m2_idle), 0);
    repeat (50) @(negedge clk);
    check("idle_set", int'(m2_idle), 1);
    prev_wr = 1'b0;
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8);
    check("idle_recover", int'(m2_idle), 0);

    // Reset in the middle of a write's high phase
    @(negedge clk);
    m2 = 1'b0; nromsel = 1'b0; nrw = 1'b0; a14 = 1'b1; a13 = 1'b0; d7 = 1'b0; d0 = 1'b1;
    repeat (7) @(negedge clk);
    m2 = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid_rst_stb", int'(wr_stb), 0);
    check("mid_rst_reg", int'(wr_reg), 0);
    check("mid_rst_d0", int'(wr_d0), 0);
    check("mid_rst_reset", int'(wr_reset), 0);
    check("mid_rst_idle", int'(m2_idle), 1);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    m2 = 1'b0;
    prev_wr = 1'b0;
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8);   // first evaluable write
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);

    repeat (20) @(negedge clk);
    check("pending_strobes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
